vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source for the Life display path: generates pixel coordinates
//  x/y for the cell renderer, and registers the renderer's rgb with blanking.
//  Produces hsync/vsync aligned to that registered rgb, plus a one-clock
//  frame_start strobe for the Life update engine.
//  Sits between the system clock and the VGA connector; the renderer is
//  combinational between x/y out and rgb_in.
// PARAMETERS
//  CLK_DIV   4     system clocks per pixel (>=1); 1 = pixel every clock
//  H_ACTIVE  1280  visible pixels per line
//  H_FP      48    horizontal front porch (pixels)
//  H_SYNC    112   hsync width (pixels)
//  H_BP      248   horizontal back porch (pixels); H_TOTAL = sum = 1688
//  V_ACTIVE  1024  visible lines
//  V_FP      1     vertical front porch (lines)
//  V_SYNC    3     vsync width (lines)
//  V_BP      38    vertical back porch (lines); V_TOTAL = sum = 1066
//  H_POL     1     hsync active level
//  V_POL     1     vsync active level
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  x            out  11  current pixel column (h_cnt), to renderer
//  y            out  11  current line (v_cnt), to renderer
//  rgb_in       in   12  renderer colour for current x/y
//  rgb_out      out  12  registered, blanked colour to DAC
//  hsync        out  1   registered horizontal sync
//  vsync        out  1   registered vertical sync
//  pix_en       out  1   one-clock pixel strobe
//  frame_start  out  1   one-clock strobe, counters at (0,0)
// BEHAVIOUR
//  Reset (async assert, sync release): div_cnt=0, h_cnt=0, v_cnt=0,
//   rgb_out=0, hsync=~H_POL, vsync=~V_POL, frame_start=0, pix_en=0.
//  Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
//   pix_en=(div_cnt==CLK_DIV-1), combinational from div_cnt.
//   If CLK_DIV==1, pix_en=1 constantly out of reset.
//  Counters advance only on pix_en:
//   h_cnt wraps H_TOTAL-1 -> 0.
//   v_cnt increments on h wrap and wraps V_TOTAL-1 -> 0 on the same edge.
//   x=h_cnt, y=v_cnt, zero-extended to 11 bits. Widths are fixed at 11 bits;
//   H_TOTAL and V_TOTAL must be <= 2048.
//  active = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE), combinational.
//  Output stage, loaded on pix_en edges only; 1-pixel latency vs x/y:
//   rgb_out <= active ? rgb_in : 12'h000
//   hsync   <= (h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]) ? H_POL : ~H_POL
//   vsync   <= (v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]) ? V_POL : ~V_POL
//   The vsync window is evaluated on v_cnt only; it changes at line start.
//  frame_start <= pix_en && h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1.
//   It is high for exactly one clk, the first clk in which counters read (0,0).
//   It never fires on the reset release itself; the first frame_start is
//   after one full frame.
//  Reset mid-frame returns all state to the reset values immediately.
//   The next frame restarts at (0,0) with no partial sync pulse.
// STRUCTURE
//  vga_pkg: H_/V_ timing localparams for 1280x1024@60 and 640x480@60,
//   plus the typedef for the 11-bit coordinate.
//  One sub-module, pix_clk_en (CLK_DIV counter -> pix_en), instantiated once.
//  Counters, compare decode and output registers stay in vga_timing_gen.
// TESTING (small params: CLK_DIV=2, H 8/1/2/1 -> H_TOTAL=12,
//          V 4/1/1/1 -> V_TOTAL=7, H_POL=V_POL=1)
//  1. Reset, release, run 10 clk -> pix_en on every 2nd clk; x steps 0..4;
//     hsync=0, vsync=0, rgb_out=0 until the first pix_en edge.
//  2. rgb_in=12'hFFF constant -> rgb_out=FFF for pixels x 0..7, 0 for x 8..11,
//     each appearing one pixel after the x value; lines 4..6 all 0.
//  3. Line timing -> hsync high exactly while registered pixel is x=9,10
//     (2 pixels = 4 clk), period 24 clk.
//  4. Frame timing -> vsync high for line y=5 only (12 px = 24 clk);
//     frame_start pulses once every 168 clk, in the clk where x=0,y=0.
//  5. Assert rst_n low at x=6,y=2 for 1 clk -> all outputs reset that clk;
//     after release, counting restarts at (0,0); frame_start not seen
//     before 168 clk.
//  6. CLK_DIV=1 rerun of 3 -> pix_en constantly 1; hsync period 12 clk.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the raster timing path.
//   coord_t          : 11-bit pixel/line coordinate (totals must fit in 2048)
//   SXGA_* / VGA_*   : porch/sync tables for 1280x1024@60 and 640x480@60
//   timing_total()   : sum of the four segments of one axis
package vga_pkg;

    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;

    // 1280x1024@60, 108 MHz pixel clock
    localparam int SXGA_H_ACTIVE = 1280;
    localparam int SXGA_H_FP     = 48;
    localparam int SXGA_H_SYNC   = 112;
    localparam int SXGA_H_BP     = 248;
    localparam int SXGA_V_ACTIVE = 1024;
    localparam int SXGA_V_FP     = 1;
    localparam int SXGA_V_SYNC   = 3;
    localparam int SXGA_V_BP     = 38;

    // 640x480@60, 25.175 MHz pixel clock
    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel-rate enable from the system clock.
//   clk_i     : system clock
//   rst_ni    : asynchronous active-low reset
//   pix_en_o  : high for one clk out of every CLK_DIV (constantly high when
//               CLK_DIV == 1), low while reset is asserted
module pix_clk_en #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic pix_en_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + DW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // With CLK_DIV == 1 the counter is stuck at LAST, so the reset term is
    // what keeps the strobe low during reset; for larger dividers it is
    // redundant (the counter reads 0 in reset).
    assign pix_en_o = rst_ni & (div_cnt_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source for the Life display path.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   x, y         : current column/line, combinational from the counters,
//                  feed the combinational cell renderer
//   rgb_in       : renderer colour for the current x/y
//   rgb_out      : colour registered one pixel after x/y, blanked outside
//                  the visible area
//   hsync, vsync : sync levels registered alongside rgb_out
//   pix_en       : one-clk pixel strobe
//   frame_start  : one-clk strobe in the first clk the counters read (0,0)
//
// Strobe semantics: pix_en and frame_start are single-clk pulses with no
// back-pressure; a consumer that misses the cycle misses the event. Every
// pixel-rate register (counters and the output stage) only moves on a clk
// edge where pix_en is high.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = SXGA_H_ACTIVE,
    parameter int   H_FP     = SXGA_H_FP,
    parameter int   H_SYNC   = SXGA_H_SYNC,
    parameter int   H_BP     = SXGA_H_BP,
    parameter int   V_ACTIVE = SXGA_V_ACTIVE,
    parameter int   V_FP     = SXGA_V_FP,
    parameter int   V_SYNC   = SXGA_V_SYNC,
    parameter int   V_BP     = SXGA_V_BP,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] x,
    output logic [10:0] y,
    input  logic [11:0] rgb_in,
    output logic [11:0] rgb_out,
    output logic        hsync,
    output logic        vsync,
    output logic        pix_en,
    output logic        frame_start
);

    // Both totals must be <= 2048 so the counters fit coord_t.
    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS      = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS      = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST    = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST    = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic        pix_en_w;
    coord_t      h_cnt_q, h_cnt_d;
    coord_t      v_cnt_q, v_cnt_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic        active;
    logic        hs_win;
    logic        vs_win;
    logic        frame_end;

    pix_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_en (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .pix_en_o (pix_en_w)
    );

    // Raster counters: v advances on the same pix_en edge that wraps h.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en_w) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + coord_t'(1);
            end else begin
                h_cnt_d = h_cnt_q + coord_t'(1);
            end
        end
    end

    // Decode of the current position. The vertical window looks at v_cnt
    // only, so vsync switches at the start of a line, not at hsync.
    always_comb begin
        active    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hs_win    = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
        vs_win    = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
        frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

        rgb_d         = active ? rgb_in : 12'h000;
        hsync_d       = hs_win ? H_POL : ~H_POL;
        vsync_d       = vs_win ? V_POL : ~V_POL;
        frame_start_d = pix_en_w && frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            rgb_q         <= 12'h000;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            // frame_start is clocked every clk so it drops after one clk
            // even when pix_en is held high.
            frame_start_q <= frame_start_d;
            if (pix_en_w) begin
                rgb_q   <= rgb_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
            end
        end
    end

    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign rgb_out     = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pix_en      = pix_en_w;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a reduced 12x7 raster. Two instances share
// clock and reset: u_dut2 divides by 2, u_dut1 runs a pixel every clk.
// The reference computes every output from the number of clk edges seen
// since reset release, using plain division/modulo over the raster.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 1, HS = 2, HB = 1;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 12
    localparam int VT = VA + VF + VS + VB;   // 7
    localparam int FRAME_PX = HT * VT;       // 84

    typedef struct {
        int x;
        int y;
        int rgb;
        int hs;
        int vs;
        int pe;
        int fs;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic mode  = 1'b0;   // 0: renderer outputs FFF, 1: coordinate pattern

    always #5 clk = ~clk;

    // Clk edges since the last reset release, and a free-running cycle count.
    int k   = 0;
    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic [10:0] x2, y2, x1, y1;
    logic [11:0] rgb_in2, rgb_in1, rgb_out2, rgb_out1;
    logic        hs2, vs2, pe2, fs2;
    logic        hs1, vs1, pe1, fs1;

    function automatic logic [11:0] pattern(input int px, input int ln);
        return {1'b1, ln[2:0], px[3:0], ~px[3:0]};
    endfunction

    assign rgb_in2 = mode ? pattern(int'(x2), int'(y2)) : 12'hFFF;
    assign rgb_in1 = mode ? pattern(int'(x1), int'(y1)) : 12'hFFF;

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .x(x2), .y(y2), .rgb_in(rgb_in2),
        .rgb_out(rgb_out2), .hsync(hs2), .vsync(vs2), .pix_en(pe2),
        .frame_start(fs2)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .rgb_in(rgb_in1),
        .rgb_out(rgb_out1), .hsync(hs1), .vsync(vs1), .pix_en(pe1),
        .frame_start(fs1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, $time, act, act, exp, exp);
        end
    endtask

    // Reference: p pixels have elapsed after kk clk edges at divider d.
    // The output stage shows pixel p-1; nothing has been loaded while p==0.
    function automatic exp_t model(input int d, input int kk, input logic rst,
                                   input logic m);
        exp_t e;
        int p, q, hp, vp;
        p   = kk / d;
        e.x = p % HT;
        e.y = (p / HT) % VT;
        e.pe = (rst && (kk % d) == d - 1) ? 1 : 0;
        if (p == 0) begin
            e.rgb = 0;
            e.hs  = 0;
            e.vs  = 0;
        end else begin
            q  = p - 1;
            hp = q % HT;
            vp = (q / HT) % VT;
            if (hp < HA && vp < VA) e.rgb = m ? int'(pattern(hp, vp)) : 32'hFFF;
            else                    e.rgb = 0;
            e.hs = (hp >= HA + HF && hp < HA + HF + HS) ? 1 : 0;
            e.vs = (vp >= VA + VF && vp < VA + VF + VS) ? 1 : 0;
        end
        e.fs = (p > 0 && (p % FRAME_PX) == 0 && (kk % d) == 0) ? 1 : 0;
        return e;
    endfunction

    // Per-cycle comparison of both instances against the reference.
    always @(negedge clk) begin
        exp_t e2, e1;
        e2 = model(2, k, rst_n, mode);
        e1 = model(1, k, rst_n, mode);
        chk("d2_x",   int'(x2),       e2.x);
        chk("d2_y",   int'(y2),       e2.y);
        chk("d2_rgb", int'(rgb_out2), e2.rgb);
        chk("d2_hs",  int'(hs2),      e2.hs);
        chk("d2_vs",  int'(vs2),      e2.vs);
        chk("d2_pe",  int'(pe2),      e2.pe);
        chk("d2_fs",  int'(fs2),      e2.fs);
        chk("d1_x",   int'(x1),       e1.x);
        chk("d1_y",   int'(y1),       e1.y);
        chk("d1_rgb", int'(rgb_out1), e1.rgb);
        chk("d1_hs",  int'(hs1),      e1.hs);
        chk("d1_vs",  int'(vs1),      e1.vs);
        chk("d1_pe",  int'(pe1),      e1.pe);
        chk("d1_fs",  int'(fs1),      e1.fs);
    end

    // Pulse widths and periods measured in clk cycles.
    int   rise_hs[2], rise_vs[2], rise_fs[2];
    bit   v_hs[2], v_vs[2], seen_fs[2];
    logic p_hs[2], p_vs[2], p_fs[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic hsn, vsn, fsn;
            int   d;
            d   = (i == 0) ? 2 : 1;
            hsn = (i == 0) ? hs2 : hs1;
            vsn = (i == 0) ? vs2 : vs1;
            fsn = (i == 0) ? fs2 : fs1;
            if (!rst_n) begin
                v_hs[i]    <= 1'b0;
                v_vs[i]    <= 1'b0;
                seen_fs[i] <= 1'b0;
            end else begin
                if (hsn && !p_hs[i]) begin
                    if (v_hs[i]) chk("hs_period", cyc - rise_hs[i], HT * d);
                    rise_hs[i] <= cyc;
                    v_hs[i]    <= 1'b1;
                end
                if (!hsn && p_hs[i] && v_hs[i]) chk("hs_width", cyc - rise_hs[i], HS * d);
                if (vsn && !p_vs[i]) begin
                    if (v_vs[i]) chk("vs_period", cyc - rise_vs[i], FRAME_PX * d);
                    rise_vs[i] <= cyc;
                    v_vs[i]    <= 1'b1;
                end
                if (!vsn && p_vs[i] && v_vs[i]) chk("vs_width", cyc - rise_vs[i], VS * HT * d);
                if (fsn && !p_fs[i]) begin
                    if (!seen_fs[i]) chk("fs_first_k", k, FRAME_PX * d);
                    else             chk("fs_period", cyc - rise_fs[i], FRAME_PX * d);
                    rise_fs[i] <= cyc;
                    seen_fs[i] <= 1'b1;
                end
            end
            p_hs[i] <= hsn;
            p_vs[i] <= vsn;
            p_fs[i] <= fsn;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_k(input int target);
        int n;
        n = 0;
        while (k != target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_k", k, target);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_x2"},   int'(x2),       0);
        chk({tag, "_y2"},   int'(y2),       0);
        chk({tag, "_rgb2"}, int'(rgb_out2), 0);
        chk({tag, "_hs2"},  int'(hs2),      0);
        chk({tag, "_vs2"},  int'(vs2),      0);
        chk({tag, "_pe2"},  int'(pe2),      0);
        chk({tag, "_fs2"},  int'(fs2),      0);
        chk({tag, "_pe1"},  int'(pe1),      0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit found;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        #2 rst_n = 1'b1;

        // First pixels after release.
        wait_k(9);
        chk("k9_x2",  int'(x2),  4);
        chk("k9_y2",  int'(y2),  0);
        chk("k9_pe2", int'(pe2), 1);
        chk("k9_x1",  int'(x1),  9);
        chk("k9_hs1", int'(hs1), 0);
        wait_k(10);
        chk("k10_hs1", int'(hs1), 1);
        chk("k10_pe2", int'(pe2), 0);
        chk("k10_rgb2", int'(rgb_out2), 32'hFFF);
        wait_k(19);
        chk("k19_hs2", int'(hs2), 0);
        chk("k19_rgb2", int'(rgb_out2), 0);
        wait_k(20);
        chk("k20_hs2", int'(hs2), 1);
        wait_k(83);
        chk("k83_fs1", int'(fs1), 0);
        wait_k(84);
        chk("k84_fs1", int'(fs1), 1);
        chk("k84_x1",  int'(x1),  0);
        chk("k84_y1",  int'(y1),  0);
        wait_k(121);
        chk("k121_vs2", int'(vs2), 0);
        wait_k(122);
        chk("k122_vs2", int'(vs2), 1);
        wait_k(167);
        chk("k167_fs2", int'(fs2), 0);
        wait_k(168);
        chk("k168_fs2", int'(fs2), 1);
        chk("k168_x2",  int'(x2),  0);
        chk("k168_y2",  int'(y2),  0);
        wait_k(400);

        // Reset pulse at (6,2) on the divide-by-2 instance.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (x2 == 11'd6 && y2 == 11'd2) found = 1'b1;
        end
        chk("mid_rst_found", int'(found), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("mid");
        mode = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;

        wait_k(2);
        chk("r2_x2",   int'(x2),       1);
        chk("r2_rgb2", int'(rgb_out2), 32'h80F);
        wait_k(4);
        chk("r4_x2",   int'(x2),       2);
        chk("r4_rgb2", int'(rgb_out2), 32'h81E);
        wait_k(400);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
